// File: rtl/h_bdy_eng_sch.sv
// Body-engine issue scheduler: round-robin arbitration, tag/credit table, completion routing and drain.
// Optional starvation guard enabled by defining H_BDY_ENG_SCH_STARVE_EN.
module h_bdy_eng_sch #(
  parameter int N_REQ = 4,
  parameter int W_OP = 32,
  parameter int N_TAG = 4,
  localparam int W_TAG = (N_TAG > 1) ? $clog2(N_TAG) : 1
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [N_REQ-1:0]   req_vld_i,
  input  logic [N_REQ*W_OP-1:0] req_op_i,
  output logic [N_REQ-1:0]   req_rdy_o,
  output logic               exe_vld_o,
  output logic [W_OP-1:0]    exe_op_o,
  output logic [W_TAG-1:0]   exe_tag_o,
  input  logic               exe_rdy_i,
  input  logic               cmpl_vld_i,
  input  logic [W_TAG-1:0]   cmpl_tag_i,
  output logic [N_REQ-1:0]   cmpl_vld_o,
  input  logic               flush_i,
  output logic               idle_o,
  output logic               err_o
);

  localparam int W_REQ = $clog2(N_REQ);
  localparam int N_TAGP = 1 << W_TAG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e              state_q;
  logic [W_REQ-1:0]    rr_q;
  logic [N_TAGP-1:0]   busy_q;
  logic [N_TAGP-1:0]   busy_d;
  logic [W_REQ-1:0]    own_q [N_TAGP];
  logic                exe_vld_q;
  logic [W_OP-1:0]     exe_op_q;
  logic [W_TAG-1:0]    exe_tag_q;
  logic [N_REQ-1:0]    cmpl_vld_q;
  logic [N_REQ-1:0]    cmpl_vld_d;
  logic                err_q;
  logic                err_d;

  logic                free_any;
  logic [W_TAG-1:0]    free_tag;
  logic                out_free;
  logic                grant_en;
  logic                win_vld;
  logic [W_REQ-1:0]    win_id;
  logic                accept;
  logic [N_REQ-1:0]    rdy;
  logic [W_OP-1:0]     win_op;
  logic                cmpl_hit;
  logic                table_empty;

`ifdef H_BDY_ENG_SCH_STARVE_EN
  logic [3:0]          cnt_q [N_REQ];
`endif

  function automatic int rr_idx(input int b, input int k);
    return (b + k) % N_REQ;
  endfunction

  assign table_empty = ~|busy_q;
  assign free_any = |(~busy_q[N_TAG-1:0]);
  assign out_free = !exe_vld_q || exe_rdy_i;
  assign grant_en = (state_q != S_DRAIN) && !flush_i
                    && free_any && out_free;

  // Lowest-index free tag among the usable entries.
  always_comb begin
    free_tag = '0;
    for (int t = N_TAG - 1; t >= 0; t--) begin
      if (!busy_q[t]) free_tag = W_TAG'(t);
    end
  end

  // Pick the first valid requester at or after the RR pointer; starved requesters override.
  always_comb begin
    win_vld = 1'b0;
    win_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld_i[rr_idx(int'(rr_q), k)]) begin
        win_vld = 1'b1;
        win_id = W_REQ'(rr_idx(int'(rr_q), k));
      end
    end
`ifdef H_BDY_ENG_SCH_STARVE_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_vld_i[i] && cnt_q[i] == 4'hF) begin
        win_vld = 1'b1;
        win_id = W_REQ'(i);
      end
    end
`endif
  end

  assign accept = grant_en && win_vld;
  assign rdy = accept ? (N_REQ'(1) << win_id) : '0;
  assign req_rdy_o = rdy;
  assign win_op = req_op_i[int'(win_id)*W_OP +: W_OP];

  assign cmpl_hit = cmpl_vld_i && busy_q[cmpl_tag_i];

  // Next tag-table occupancy, completion routing and protocol error.
  always_comb begin
    busy_d = busy_q;
    cmpl_vld_d = '0;
    err_d = err_q;
    if (cmpl_vld_i) begin
      if (cmpl_hit) begin
        busy_d[cmpl_tag_i] = 1'b0;
        cmpl_vld_d = N_REQ'(1) << own_q[cmpl_tag_i];
      end else begin
        err_d = 1'b1;
      end
    end
    if (accept) busy_d[free_tag] = 1'b1;
  end

  // Scheduler FSM: IDLE / RUN / DRAIN.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_i) state_q <= S_DRAIN;
          else if (|req_vld_i) state_q <= S_RUN;
        end
        S_RUN: begin
          if (flush_i) state_q <= S_DRAIN;
          else if (!(|req_vld_i) && !exe_vld_q && table_empty)
            state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (!flush_i && !exe_vld_q && table_empty)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RR pointer and the held output op register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q <= '0;
      exe_vld_q <= 1'b0;
      exe_op_q <= '0;
      exe_tag_q <= '0;
    end else begin
      if (accept) begin
        if (win_id == W_REQ'(N_REQ - 1)) rr_q <= '0;
        else rr_q <= win_id + W_REQ'(1);
      end
      if (out_free) begin
        exe_vld_q <= accept;
        if (accept) begin
          exe_op_q <= win_op;
          exe_tag_q <= free_tag;
        end
      end
    end
  end

  // Tag table, owner ids, completion pulse and sticky error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= '0;
      cmpl_vld_q <= '0;
      err_q <= 1'b0;
      for (int t = 0; t < N_TAGP; t++) own_q[t] <= '0;
    end else begin
      busy_q <= busy_d;
      cmpl_vld_q <= cmpl_vld_d;
      err_q <= err_d;
      if (accept) own_q[free_tag] <= win_id;
    end
  end

`ifdef H_BDY_ENG_SCH_STARVE_EN
  // Per-requester wait counters, saturating at 15, cleared on grant.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rdy[i]) cnt_q[i] <= '0;
        else if (req_vld_i[i] && cnt_q[i] != 4'hF)
          cnt_q[i] <= cnt_q[i] + 4'd1;
      end
    end
  end
`endif

  assign exe_vld_o = exe_vld_q;
  assign exe_op_o = exe_op_q;
  assign exe_tag_o = exe_tag_q;
  assign cmpl_vld_o = cmpl_vld_q;
  assign err_o = err_q;
  assign idle_o = table_empty && !exe_vld_q && (state_q != S_RUN);

endmodule

// File: tb/tb_h_bdy_eng_sch.sv
// Directed table-driven bench for h_bdy_eng_sch.
// Default build: 4 requesters, 32-bit ops, 4 tags.
module tb_h_bdy_eng_sch;

  localparam int N_REQ = 4;
  localparam int W_OP = 32;
  localparam int N_TAG = 4;
  localparam int W_TAG = 2;

  logic                    clk;
  logic                    arst_n;
  logic [N_REQ-1:0]        req_vld_i;
  logic [N_REQ*W_OP-1:0]   req_op_i;
  logic [N_REQ-1:0]        req_rdy_o;
  logic                    exe_vld_o;
  logic [W_OP-1:0]         exe_op_o;
  logic [W_TAG-1:0]        exe_tag_o;
  logic                    exe_rdy_i;
  logic                    cmpl_vld_i;
  logic [W_TAG-1:0]        cmpl_tag_i;
  logic [N_REQ-1:0]        cmpl_vld_o;
  logic                    flush_i;
  logic                    idle_o;
  logic                    err_o;

  h_bdy_eng_sch #(
    .N_REQ(N_REQ),
    .W_OP(W_OP),
    .N_TAG(N_TAG)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .req_vld_i(req_vld_i),
    .req_op_i(req_op_i),
    .req_rdy_o(req_rdy_o),
    .exe_vld_o(exe_vld_o),
    .exe_op_o(exe_op_o),
    .exe_tag_o(exe_tag_o),
    .exe_rdy_i(exe_rdy_i),
    .cmpl_vld_i(cmpl_vld_i),
    .cmpl_tag_i(cmpl_tag_i),
    .cmpl_vld_o(cmpl_vld_o),
    .flush_i(flush_i),
    .idle_o(idle_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       erdy;
    logic       cv;
    logic [1:0] ct;
    logic       fl;
    logic [3:0] rdy;
    logic       ev;
    logic [1:0] et;
    logic [1:0] eo;
    logic [3:0] co;
    logic       er;
    logic       idl;
  } vec_t;

  vec_t vecs[$];
  int n_vec;
  int n_miss;

  function automatic vec_t mk(
    input logic [3:0] vld, input logic erdy, input logic cv,
    input logic [1:0] ct, input logic fl, input logic [3:0] rdy,
    input logic ev, input logic [1:0] et, input logic [1:0] eo,
    input logic [3:0] co, input logic er, input logic idl);
    vec_t v;
    v.vld = vld; v.erdy = erdy; v.cv = cv; v.ct = ct; v.fl = fl;
    v.rdy = rdy; v.ev = ev; v.et = et; v.eo = eo;
    v.co = co; v.er = er; v.idl = idl;
    return v;
  endfunction

  function automatic logic [W_OP-1:0] op_of(input int id);
    return 32'hC0DE_0000 | W_OP'(id);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic erdy,
                       input logic cv, input logic [1:0] ct,
                       input logic fl);
    req_vld_i = vld;
    exe_rdy_i = erdy;
    cmpl_vld_i = cv;
    cmpl_tag_i = ct;
    flush_i = fl;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    arst_n = 1'b0;
    drive(4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < N_REQ; i++) req_op_i[i*W_OP +: W_OP] = op_of(i);

    // Continuous RR with completions three cycles after issue.
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h0,0,1));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h1,0,0,0,4'h0,0,1));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h2,1,0,0,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,1,0,0, 4'h4,1,1,1,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,1,1,0, 4'h8,1,2,2,4'h1,0,0));
    vecs.push_back(mk(4'hF,1,1,2,0, 4'h1,1,0,3,4'h2,0,0));
    vecs.push_back(mk(4'h0,1,1,0,0, 4'h0,1,1,0,4'h4,0,0));
    vecs.push_back(mk(4'h0,1,1,1,0, 4'h0,0,0,0,4'h8,0,0));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h1,0,0));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h0,0,1));
    // Fill the table with no completions, then free tag 2.
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h2,0,0,0,4'h0,0,1));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h4,1,0,1,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h8,1,1,2,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h1,1,2,3,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h0,1,3,0,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,1,2,0, 4'h0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,0,0,0, 4'h2,0,0,0,4'h8,0,0));
    // Execute stall for five cycles: held op stays stable.
    for (int s = 0; s < 5; s++)
      vecs.push_back(mk(4'hF,0,0,0,0, 4'h0,1,2,1,4'h0,0,0));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,1,2,1,4'h0,0,0));
    // Flush with ops in flight, drain through completions.
    vecs.push_back(mk(4'hF,1,1,0,1, 4'h0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(4'hF,1,1,1,1, 4'h0,0,0,0,4'h2,0,0));
    vecs.push_back(mk(4'hF,1,1,2,1, 4'h0,0,0,0,4'h4,0,0));
    vecs.push_back(mk(4'h0,1,1,3,1, 4'h0,0,0,0,4'h2,0,0));
    vecs.push_back(mk(4'h0,1,0,0,1, 4'h0,0,0,0,4'h1,0,1));
    vecs.push_back(mk(4'h1,1,0,0,0, 4'h0,0,0,0,4'h0,0,1));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h0,0,1));
    // Completion on a free tag: sticky error, table untouched.
    vecs.push_back(mk(4'h0,1,1,1,0, 4'h0,0,0,0,4'h0,0,1));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h0,1,1));
    vecs.push_back(mk(4'h1,1,0,0,0, 4'h1,0,0,0,4'h0,1,1));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,1,0,0,4'h0,1,0));
    vecs.push_back(mk(4'h0,1,1,0,0, 4'h0,0,0,0,4'h0,1,0));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h1,1,0));
    vecs.push_back(mk(4'h0,1,0,0,0, 4'h0,0,0,0,4'h0,1,1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].vld, vecs[i].erdy, vecs[i].cv, vecs[i].ct, vecs[i].fl);
      #1;
      n_vec++;
      chk("req_rdy", i, 32'(req_rdy_o), 32'(vecs[i].rdy));
      chk("exe_vld", i, 32'(exe_vld_o), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk("exe_tag", i, 32'(exe_tag_o), 32'(vecs[i].et));
        chk("exe_op", i, exe_op_o, op_of(int'(vecs[i].eo)));
      end
      chk("cmpl_vld", i, 32'(cmpl_vld_o), 32'(vecs[i].co));
      chk("err", i, 32'(err_o), 32'(vecs[i].er));
      chk("idle", i, 32'(idle_o), 32'(vecs[i].idl));
    end

    // Mid-operation reset clears everything; late completion flags error.
    @(negedge clk);
    drive(4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    n_vec++;
    chk("pre_rst_rdy", 0, 32'(req_rdy_o), 32'h2);
    @(negedge clk);
    drive(4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    n_vec++;
    chk("pre_rst_vld", 0, 32'(exe_vld_o), 32'h1);
    chk("pre_rst_idle", 0, 32'(idle_o), 32'h0);
    arst_n = 1'b0;
    #1;
    n_vec++;
    chk("rst_vld", 0, 32'(exe_vld_o), 32'h0);
    chk("rst_op", 0, exe_op_o, 32'h0);
    chk("rst_tag", 0, 32'(exe_tag_o), 32'h0);
    chk("rst_err", 0, 32'(err_o), 32'h0);
    chk("rst_idle", 0, 32'(idle_o), 32'h1);
    chk("rst_cmpl", 0, 32'(cmpl_vld_o), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    drive(4'hC, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    n_vec++;
    chk("post_rst_rr", 0, 32'(req_rdy_o), 32'h4);
    @(negedge clk);
    drive(4'h0, 1'b1, 1'b1, 2'd1, 1'b0);
    #1;
    n_vec++;
    chk("post_rst_tag", 0, 32'(exe_tag_o), 32'h0);
    chk("post_rst_op", 0, exe_op_o, op_of(2));
    @(negedge clk);
    drive(4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    n_vec++;
    chk("late_cmpl_err", 0, 32'(err_o), 32'h1);
    chk("late_cmpl_pulse", 0, 32'(cmpl_vld_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
